// File: rtl/ddram_pkg.sv
// rtl/ddram_pkg.sv - shared widths, responder states and window base for the DDRAM port
package ddram_pkg;

    localparam int DDRAM_AW  = 29;
    localparam int DDRAM_DW  = 64;
    localparam int DDRAM_BEW = 8;

    localparam logic [DDRAM_AW-1:0] DDRAM_BASE_30M = 29'h0600_0000;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } ddram_rsp_state_t;

endpackage

// File: rtl/ddram_bram_be.sv
// rtl/ddram_bram_be.sv - simple dual-port byte-enable RAM with RD_LAT-stage registered read
module ddram_bram_be
    import ddram_pkg::*;
#(
    parameter int AW     = 12,
    parameter int RD_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DDRAM_DW-1:0]  wdata_i,
    input  logic [DDRAM_BEW-1:0] wbe_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [DDRAM_DW-1:0]  rdata_o
);

    logic [DDRAM_DW-1:0] mem [0:(1<<AW)-1];
    logic [DDRAM_DW-1:0] pipe_q [RD_LAT];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < DDRAM_BEW; k++) begin
                if (wbe_i[k]) begin
                    mem[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Output registers are cleared on reset so the read data bus idles at zero; the array is not.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (re_i) begin
                pipe_q[0] <= mem[raddr_i];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/ddram_bram_responder.sv
// rtl/ddram_bram_responder.sv - DDRAM-port responder: burst FSM, window check and BRAM backing store
module ddram_bram_responder
    import ddram_pkg::*;
#(
    parameter int                  AW     = 12,
    parameter int                  RD_LAT = 2,
    parameter logic [DDRAM_AW-1:0] BASE   = DDRAM_BASE_30M
) (
    input  logic                 DDRAM_CLK,
    input  logic                 reset,
    output logic                 DDRAM_BUSY,
    input  logic [7:0]           DDRAM_BURSTCNT,
    input  logic [DDRAM_AW-1:0]  DDRAM_ADDR,
    input  logic                 DDRAM_RD,
    input  logic                 DDRAM_WE,
    input  logic [DDRAM_DW-1:0]  DDRAM_DIN,
    input  logic [DDRAM_BEW-1:0] DDRAM_BE,
    output logic [DDRAM_DW-1:0]  DDRAM_DOUT,
    output logic                 DDRAM_DOUT_READY,
    input  logic                 stall,
    output logic                 err
);

    ddram_rsp_state_t state_q, state_d;

    logic [7:0]    wcnt_q;
    logic [AW-1:0] waddr_q;
    logic          wwin_q;
    logic [AW-1:0] raddr_q;
    logic          rwin_q;
    logic [7:0]    issue_q;
    logic [7:0]    left_q;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] zero_q;
    logic          err_q;

    logic          busy;
    logic          cmd_win;
    logic [AW-1:0] cmd_off;
    logic [7:0]    bc_eff;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_issue;
    logic          err_set;
    logic          pre_vld;
    logic [DDRAM_DW-1:0] ram_rdata;

    assign busy    = (state_q == RBURST) | stall;
    assign cmd_win = (DDRAM_ADDR[DDRAM_AW-1:AW] == BASE[DDRAM_AW-1:AW]);
    assign cmd_off = DDRAM_ADDR[AW-1:0] - BASE[AW-1:0];
    assign bc_eff  = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

    // pre_vld is the beat that the coming edge will present on DOUT_READY.
    generate
        if (RD_LAT == 1) begin : g_pre_issue
            assign pre_vld = rd_issue;
        end else begin : g_pre_pipe
            assign pre_vld = vld_q[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (DDRAM_WE && !busy) begin
                    if (bc_eff != 8'd1) begin
                        state_d = WBURST;
                    end
                end else if (DDRAM_RD && !busy) begin
                    state_d = RBURST;
                end
            end
            WBURST: begin
                if (DDRAM_WE && !stall && wcnt_q == 8'd1) begin
                    state_d = IDLE;
                end
            end
            RBURST: begin
                if (pre_vld && left_q == 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = cmd_off;
        rd_issue = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en   = DDRAM_WE & ~busy & cmd_win;
                err_set = (DDRAM_WE | DDRAM_RD) & ~busy & (~cmd_win | (DDRAM_WE & DDRAM_RD));
            end
            WBURST: begin
                wr_en   = DDRAM_WE & ~stall & wwin_q;
                wr_addr = waddr_q;
                err_set = DDRAM_RD & ~stall;
            end
            RBURST: begin
                rd_issue = ~stall & (issue_q != 8'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            wcnt_q  <= '0;
            waddr_q <= '0;
            wwin_q  <= 1'b0;
            raddr_q <= '0;
            rwin_q  <= 1'b0;
            issue_q <= '0;
            left_q  <= '0;
            vld_q   <= '0;
            zero_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            vld_q[0]  <= rd_issue;
            zero_q[0] <= rd_issue & ~rwin_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                zero_q[i] <= zero_q[i-1];
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (DDRAM_WE && !busy) begin
                        wcnt_q  <= bc_eff - 8'd1;
                        waddr_q <= cmd_off + AW'(1);
                        wwin_q  <= cmd_win;
                    end else if (DDRAM_RD && !busy) begin
                        raddr_q <= cmd_off;
                        rwin_q  <= cmd_win;
                        issue_q <= bc_eff;
                        left_q  <= bc_eff;
                    end
                end
                WBURST: begin
                    if (DDRAM_WE && !stall) begin
                        wcnt_q  <= wcnt_q - 8'd1;
                        waddr_q <= waddr_q + AW'(1);
                    end
                end
                RBURST: begin
                    if (rd_issue) begin
                        raddr_q <= raddr_q + AW'(1);
                        issue_q <= issue_q - 8'd1;
                    end
                    if (pre_vld) begin
                        left_q <= left_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    ddram_bram_be #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk_i   (DDRAM_CLK),
        .reset_i (reset),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (DDRAM_DIN),
        .wbe_i   (DDRAM_BE),
        .re_i    (rd_issue),
        .raddr_i (raddr_q),
        .rdata_o (ram_rdata)
    );

    // Out-of-window reads travel the pipeline like any other beat but are forced to zero.
    assign DDRAM_DOUT       = zero_q[RD_LAT-1] ? '0 : ram_rdata;
    assign DDRAM_DOUT_READY = vld_q[RD_LAT-1];
    assign DDRAM_BUSY       = busy;
    assign err              = err_q;

endmodule
